addsub_job_scheduler: RTL and testbench

Shared-resource scheduler for the 8-bit add/sub datapath. Two requesters each submit a job of four operands (A, B, C, D) and a mode. The block arbitrates round-robin and sequences one shared adder/subtractor over three steps. It returns an 8-bit result, the requester id and an overflow flag through a valid/ready handshake.

---
 rtl/addsub_job_scheduler_pkg.sv | 34 +++
 rtl/addsub_job_scheduler_if.sv | 40 ++++
 rtl/addsub_job_scheduler_unit.sv | 27 ++
 rtl/addsub_job_scheduler.sv | 154 +++++++++++++++
 tb/tb_addsub_job_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_job_scheduler_pkg.sv
// Shared definitions for the add/sub job scheduler: FSM states, modes and
// the per-mode step-operation table.
package addsub_sched_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S_B  = 3'd1,
        S_C  = 3'd2,
        S_D  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic MODE_ADD = 1'b0;  // A + B + C - D
    localparam logic MODE_SUB = 1'b1;  // A - B - C + D

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Indexed by mode; bit 0/1/2 is the operation applied with B/C/D.
    localparam logic [1:0][2:0] OP_SEQ = {
        {OP_ADD, OP_SUB, OP_SUB},
        {OP_SUB, OP_ADD, OP_ADD}
    };

    function automatic logic step_op(input logic mode, input state_t st);
        case (st)
            S_B:     return OP_SEQ[mode][0];
            S_C:     return OP_SEQ[mode][1];
            S_D:     return OP_SEQ[mode][2];
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/addsub_job_scheduler_if.sv
// Requester, result and status signals of the add/sub job scheduler.
// master = requesters/consumer side, slave = the scheduler.
interface addsub_job_scheduler_if #(
    parameter int WIDTH = 8
);

    logic               req0;
    logic [4*WIDTH-1:0] opnd0;
    logic               mode0;
    logic               ack0;

    logic               req1;
    logic [4*WIDTH-1:0] opnd1;
    logic               mode1;
    logic               ack1;

    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   result;
    logic               res_id;
    logic               ovf;
    logic               busy;

    modport master (
        output req0, opnd0, mode0,
        output req1, opnd1, mode1,
        output res_ready,
        input  ack0, ack1,
        input  res_valid, result, res_id, ovf, busy
    );

    modport slave (
        input  req0, opnd0, mode0,
        input  req1, opnd1, mode1,
        input  res_ready,
        output ack0, ack1,
        output res_valid, result, res_id, ovf, busy
    );

endinterface

// File: rtl/addsub_job_scheduler_unit.sv
// The single shared WIDTH-bit adder/subtractor; cout_borrow is the carry-out
// on add and the borrow on subtract.
module addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout_borrow
);

    logic [WIDTH:0] wide;

    // A zero-extended subtract leaves the borrow in the top bit.
    always_comb begin
        if (sub) begin
            wide = {1'b0, a} - {1'b0, b};
        end else begin
            wide = {1'b0, a} + {1'b0, b};
        end
    end

    assign sum         = wide[WIDTH-1:0];
    assign cout_borrow = wide[WIDTH];

endmodule

// File: rtl/addsub_job_scheduler.sv
// Round-robin scheduler for two requesters sharing one add/sub unit; each job
// is A op B op C op D over three steps, returned through a valid/ready port.
module addsub_job_scheduler
    import addsub_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                  clock,
    input logic                  reset,
    addsub_job_scheduler_if.slave bus
);

    state_t state_q, state_d;

    logic               grant;
    logic               grant_id;
    logic [4*WIDTH-1:0] sel_opnd;
    logic               sel_mode;

    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   b_q, c_q, d_q;
    logic               mode_q;
    logic               id_q;
    logic               ovf_acc_q;
    logic               last_grant_q;

    logic               ack0_q, ack1_q;
    logic               res_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               res_id_q;
    logic               ovf_q;

    logic [WIDTH-1:0]   operand;
    logic               step_sub;
    logic [WIDTH-1:0]   step_sum;
    logic               step_cout;

    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_id = 1'b0;
        operand  = b_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    grant    = 1'b1;
                    grant_id = ~last_grant_q;
                end else if (bus.req0) begin
                    grant    = 1'b1;
                    grant_id = 1'b0;
                end else if (bus.req1) begin
                    grant    = 1'b1;
                    grant_id = 1'b1;
                end
                if (grant) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                operand = b_q;
                state_d = S_C;
            end
            S_C: begin
                operand = c_q;
                state_d = S_D;
            end
            S_D: begin
                operand = d_q;
                state_d = DONE;
            end
            DONE: begin
                if (res_valid_q && bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign step_sub = step_op(mode_q, state_q);
    assign sel_opnd = grant_id ? bus.opnd1 : bus.opnd0;
    assign sel_mode = grant_id ? bus.mode1 : bus.mode0;

    addsub_unit #(.WIDTH(WIDTH)) u_addsub (
        .a           (acc_q),
        .b           (operand),
        .sub         (step_sub),
        .sum         (step_sum),
        .cout_borrow (step_cout)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q        <= '0;
            b_q          <= '0;
            c_q          <= '0;
            d_q          <= '0;
            mode_q       <= MODE_ADD;
            id_q         <= 1'b0;
            ovf_acc_q    <= 1'b0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            result_q     <= '0;
            res_id_q     <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            ack0_q <= grant && !grant_id;
            ack1_q <= grant && grant_id;
            if (grant) begin
                acc_q        <= sel_opnd[4*WIDTH-1 -: WIDTH];
                b_q          <= sel_opnd[3*WIDTH-1 -: WIDTH];
                c_q          <= sel_opnd[2*WIDTH-1 -: WIDTH];
                d_q          <= sel_opnd[WIDTH-1:0];
                mode_q       <= sel_mode;
                id_q         <= grant_id;
                ovf_acc_q    <= 1'b0;
                last_grant_q <= grant_id;
            end else if (state_q == S_B || state_q == S_C) begin
                acc_q     <= step_sum;
                ovf_acc_q <= ovf_acc_q | step_cout;
            end else if (state_q == S_D) begin
                result_q    <= step_sum;
                ovf_q       <= ovf_acc_q | step_cout;
                res_id_q    <= id_q;
                res_valid_q <= 1'b1;
            end else if (state_q == DONE && res_valid_q && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;
    assign bus.res_id    = res_id_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_addsub_job_scheduler.sv
// Directed bench for addsub_job_scheduler: stimulus pushes expected results
// into a scoreboard that an independent monitor drains on each handshake.
module tb_addsub_job_scheduler;
    import addsub_sched_pkg::*;

    localparam int WIDTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    addsub_job_scheduler_if #(.WIDTH(WIDTH)) bus ();

    addsub_job_scheduler #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             id;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   grant_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_job(input logic [WIDTH-1:0] r, input logic id, input logic o);
        exp_t e;
        e.result = r;
        e.id     = id;
        e.ovf    = o;
        sb.push_back(e);
    endtask

    // Monitor: ack exclusivity, grant order and result scoreboard.
    always @(negedge clock) begin
        if (bus.ack0 || bus.ack1) begin
            check("ack_exclusive", {31'd0, bus.ack0 & bus.ack1}, 0);
        end
        if (bus.ack0) grant_q.push_back(0);
        if (bus.ack1) grant_q.push_back(1);
        if (bus.res_valid && bus.res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", {31'd0, bus.res_valid}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {24'd0, bus.result}, {24'd0, e.result});
                check("res_id", {31'd0, bus.res_id}, {31'd0, e.id});
                check("ovf",    {31'd0, bus.ovf},    {31'd0, e.ovf});
            end
        end
    end

    task automatic drive_req(input int id, input logic mode,
                             input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input logic [7:0] d);
        if (id == 0) begin
            bus.req0  = 1'b1;
            bus.mode0 = mode;
            bus.opnd0 = {a, b, c, d};
        end else begin
            bus.req1  = 1'b1;
            bus.mode1 = mode;
            bus.opnd1 = {a, b, c, d};
        end
    endtask

    task automatic drop_req(input int id);
        if (id == 0) bus.req0 = 1'b0;
        else         bus.req1 = 1'b0;
    endtask

    // Returns at the negedge where the ack is visible and drops the request.
    task automatic wait_ack(input int id, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            seen = (id == 0) ? bus.ack0 : bus.ack1;
        end
        check({name, "_ack"}, {31'd0, seen}, 1);
        if (seen) drop_req(id);
    endtask

    // From the ack negedge: ack is a single pulse, res_valid on the third edge.
    task automatic check_latency(input int id, input string name);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clock);
            check({name, "_valid_latency"}, {31'd0, bus.res_valid}, (i == 3) ? 1 : 0);
            if (i == 1) begin
                check({name, "_ack_pulse"}, {31'd0, (id == 0) ? bus.ack0 : bus.ack1}, 0);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ack0"},      {31'd0, bus.ack0}, 0);
        check({name, "_ack1"},      {31'd0, bus.ack1}, 0);
        check({name, "_res_valid"}, {31'd0, bus.res_valid}, 0);
        check({name, "_result"},    {24'd0, bus.result}, 0);
        check({name, "_res_id"},    {31'd0, bus.res_id}, 0);
        check({name, "_ovf"},       {31'd0, bus.ovf}, 0);
        check({name, "_busy"},      {31'd0, bus.busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req0 = 1'b0; bus.opnd0 = '0; bus.mode0 = 1'b0;
        bus.req1 = 1'b0; bus.opnd1 = '0; bus.mode1 = 1'b0;
        bus.res_ready = 1'b1;

        #12;
        check_outputs_zero("reset");
        @(posedge clock); #1 reset = 1'b1;

        // 1: requester 0, carry on +FF
        expect_job(8'h00, 1'b0, 1'b1);
        drive_req(0, MODE_ADD, 8'h01, 8'h02, 8'hFF, 8'h02);
        wait_ack(0, "t1");
        check_latency(0, "t1");
        @(posedge clock); #1;

        // 2: requester 1 only, subtract mode
        expect_job(8'h0F, 1'b1, 1'b0);
        drive_req(1, MODE_SUB, 8'h10, 8'h02, 8'h03, 8'h04);
        wait_ack(1, "t2");
        check_latency(1, "t2");
        @(posedge clock); #1;
        @(negedge clock);
        check("t2_retain_result", {24'd0, bus.result}, 32'h0F);
        check("t2_retain_id",     {31'd0, bus.res_id}, 1);
        check("t2_valid_cleared", {31'd0, bus.res_valid}, 0);
        check("t2_idle",          {31'd0, bus.busy}, 0);

        // 3: both requesting from reset, round-robin 0, 1, 0
        @(posedge clock); #1 reset = 1'b0;
        grant_q.delete();
        expect_job(8'h22, 1'b0, 1'b0);
        expect_job(8'h25, 1'b1, 1'b0);
        expect_job(8'h0F, 1'b0, 1'b1);
        drive_req(0, MODE_ADD, 8'h11, 8'h22, 8'h33, 8'h44);
        drive_req(1, MODE_SUB, 8'h50, 8'h10, 8'h20, 8'h05);
        @(posedge clock); #1 reset = 1'b1;
        wait_ack(0, "t3a");
        check_latency(0, "t3a");
        drive_req(0, MODE_ADD, 8'hF0, 8'h20, 8'h00, 8'h01);
        wait_ack(1, "t3b");
        check_latency(1, "t3b");
        wait_ack(0, "t3c");
        check_latency(0, "t3c");
        @(posedge clock); #1;
        check("t3_grant_count", grant_q.size(), 3);
        if (grant_q.size() == 3) begin
            check("t3_grant0", grant_q[0], 0);
            check("t3_grant1", grant_q[1], 1);
            check("t3_grant2", grant_q[2], 0);
        end

        // 4: backpressure with requester 1 pending
        bus.res_ready = 1'b0;
        expect_job(8'h01, 1'b0, 1'b1);
        expect_job(8'h1B, 1'b1, 1'b0);
        drive_req(0, MODE_ADD, 8'h80, 8'h80, 8'h01, 8'h00);
        wait_ack(0, "t4a");
        drive_req(1, MODE_SUB, 8'h20, 8'h05, 8'h05, 8'h05);
        check_latency(0, "t4a");
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t4_hold_valid",  {31'd0, bus.res_valid}, 1);
            check("t4_hold_result", {24'd0, bus.result}, 32'h01);
            check("t4_hold_id",     {31'd0, bus.res_id}, 0);
            check("t4_hold_ovf",    {31'd0, bus.ovf}, 1);
            check("t4_no_ack1",     {31'd0, bus.ack1}, 0);
        end
        @(posedge clock); #1 bus.res_ready = 1'b1;
        @(negedge clock);
        check("t4_no_ack1_done", {31'd0, bus.ack1}, 0);
        @(negedge clock);
        check("t4_idle_after_hs", {31'd0, bus.busy}, 0);
        check("t4_no_same_edge_grant", {31'd0, bus.ack1}, 0);
        @(negedge clock);
        check("t4b_ack", {31'd0, bus.ack1}, 1);
        drop_req(1);
        check_latency(1, "t4b");
        @(posedge clock); #1;

        // 5: reset during S_C discards the job
        expect_job(8'h11, 1'b0, 1'b0);
        drive_req(0, MODE_ADD, 8'h10, 8'h01, 8'h01, 8'h01);
        wait_ack(0, "t5a");
        @(posedge clock); #2;
        check("t5_busy_before_reset", {31'd0, bus.busy}, 1);
        reset = 1'b0;
        #1;
        check_outputs_zero("t5_reset");
        sb.delete(sb.size() - 1);
        @(posedge clock); #1 reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("t5_no_valid", {31'd0, bus.res_valid}, 0);
            check("t5_no_reack", {31'd0, bus.ack0}, 0);
        end
        expect_job(8'h02, 1'b0, 1'b0);
        drive_req(0, MODE_ADD, 8'h01, 8'h01, 8'h01, 8'h01);
        wait_ack(0, "t5b");
        check_latency(0, "t5b");
        @(posedge clock); #1;

        // 6: borrow in subtract mode
        expect_job(8'hFF, 1'b0, 1'b1);
        drive_req(0, MODE_SUB, 8'h00, 8'h01, 8'h00, 8'h00);
        wait_ack(0, "t6");
        check_latency(0, "t6");
        @(posedge clock); #1;

        @(negedge clock);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
